// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - reorder buffer defaults and entry type
package reorder_buffer_pkg;

    localparam int default_rob_size          = 16;
    localparam int default_rob_index_bits    = 4;
    localparam int default_alu_rs_size       = 8;
    localparam int default_alu_rs_index_bits = 3;

    typedef struct packed {
        logic                                 valid;
        logic                                 done;
        logic [4:0]                           rd;
        logic [31:0]                          data;
        logic [default_alu_rs_index_bits-1:0] slot;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// rtl/rob_ptr_ctrl.sv - head/tail/count bookkeeping for the reorder buffer
module rob_ptr_ctrl #(
    parameter int rob_size       = 16,
    parameter int rob_index_bits = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      commit_ready,
    output logic                      alloc_en,
    output logic                      commit_en,
    output logic [rob_index_bits-1:0] head,
    output logic [rob_index_bits-1:0] tail,
    output logic                      full,
    output logic                      empty
);

    logic [rob_index_bits:0] count;

    // Full is taken from the registered count, so a same-cycle commit never frees a slot early.
    assign full      = (count == (rob_index_bits+1)'(rob_size));
    assign empty     = (count == '0);
    assign alloc_en  = load & ~full;
    assign commit_en = commit_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_en)
                tail <= tail + 1'b1;
            if (commit_en)
                head <= head + 1'b1;
            unique case ({alloc_en, commit_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order ROB with result capture and broadcast; optional ROB_PERF_COUNTERS_EN
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int rob_size          = default_rob_size,
    parameter int rob_index_bits    = default_rob_index_bits,
    parameter int alu_rs_size       = default_alu_rs_size,
    parameter int alu_rs_index_bits = default_alu_rs_index_bits
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load_rob_dec,
    input  logic [4:0]                        rd_dec,
    input  logic                              ready_dec,
    input  logic [31:0]                       data_dec,
    input  logic [alu_rs_index_bits-1:0]      widx_alurs,
    input  logic [alu_rs_size-1:0]            done_alurs,
    input  logic [alu_rs_size-1:0][31:0]      data_alurs,
    output logic [rob_index_bits-1:0]         widx_rob,
    output logic                              rob_full,
    output logic                              rob_empty,
    output logic [rob_size-1:0]               done_rob,
    output logic [rob_size-1:0][31:0]         data_rob,
    output logic                              commit_valid_rob,
    output logic [4:0]                        commit_rd_rob,
    output logic [31:0]                       commit_data_rob,
    output logic [rob_index_bits-1:0]         commit_idx_rob
`ifdef ROB_PERF_COUNTERS_EN
    ,
    output logic [31:0]                       commit_total_rob,
    output logic [31:0]                       full_cycles_rob
`endif
);

    rob_entry_t                entry_q [rob_size];
    logic [rob_index_bits-1:0] head;
    logic [rob_index_bits-1:0] tail;
    logic                      alloc_en;
    logic                      commit_en;
    logic                      commit_ready;

    assign commit_ready = entry_q[head].valid & entry_q[head].done;

    rob_ptr_ctrl #(
        .rob_size       (rob_size),
        .rob_index_bits (rob_index_bits)
    ) u_ptr (
        .clk          (clk),
        .rst          (rst),
        .load         (load_rob_dec),
        .commit_ready (commit_ready),
        .alloc_en     (alloc_en),
        .commit_en    (commit_en),
        .head         (head),
        .tail         (tail),
        .full         (rob_full),
        .empty        (rob_empty)
    );

    // Capture only looks at already-valid entries, so a fresh entry cannot see its slot's stale done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < rob_size; i++)
                entry_q[i] <= '0;
        end else begin
            for (int i = 0; i < rob_size; i++) begin
                if (entry_q[i].valid && !entry_q[i].done && done_alurs[entry_q[i].slot]) begin
                    entry_q[i].done <= 1'b1;
                    entry_q[i].data <= data_alurs[entry_q[i].slot];
                end
            end
            if (commit_en) begin
                entry_q[head].valid <= 1'b0;
                entry_q[head].done  <= 1'b0;
            end
            if (alloc_en) begin
                entry_q[tail] <= '{valid: 1'b1,
                                   done:  ready_dec,
                                   rd:    rd_dec,
                                   data:  ready_dec ? data_dec : 32'd0,
                                   slot:  widx_alurs};
            end
        end
    end

    always_comb begin
        done_rob = '0;
        data_rob = '0;
        for (int i = 0; i < rob_size; i++) begin
            done_rob[i] = entry_q[i].valid & entry_q[i].done;
            data_rob[i] = entry_q[i].data;
        end
    end

    assign widx_rob         = tail;
    assign commit_valid_rob = commit_ready;
    assign commit_rd_rob    = entry_q[head].rd;
    assign commit_data_rob  = entry_q[head].data;
    assign commit_idx_rob   = head;

`ifdef ROB_PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            commit_total_rob <= '0;
            full_cycles_rob  <= '0;
        end else begin
            if (commit_en)
                commit_total_rob <= commit_total_rob + 32'd1;
            if (rob_full)
                full_cycles_rob <= full_cycles_rob + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - self-checking bench for reorder_buffer
module tb_reorder_buffer;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              load_rob_dec;
    logic [4:0]        rd_dec;
    logic              ready_dec;
    logic [31:0]       data_dec;
    logic [2:0]        widx_alurs;
    logic [7:0]        done_alurs;
    logic [7:0][31:0]  data_alurs;
    logic [3:0]        widx_rob;
    logic              rob_full;
    logic              rob_empty;
    logic [15:0]       done_rob;
    logic [15:0][31:0] data_rob;
    logic              commit_valid_rob;
    logic [4:0]        commit_rd_rob;
    logic [31:0]       commit_data_rob;
    logic [3:0]        commit_idx_rob;

    int checks = 0;
    int errors = 0;

    reorder_buffer dut (
        .clk              (clk),
        .rst              (rst),
        .load_rob_dec     (load_rob_dec),
        .rd_dec           (rd_dec),
        .ready_dec        (ready_dec),
        .data_dec         (data_dec),
        .widx_alurs       (widx_alurs),
        .done_alurs       (done_alurs),
        .data_alurs       (data_alurs),
        .widx_rob         (widx_rob),
        .rob_full         (rob_full),
        .rob_empty        (rob_empty),
        .done_rob         (done_rob),
        .data_rob         (data_rob),
        .commit_valid_rob (commit_valid_rob),
        .commit_rd_rob    (commit_rd_rob),
        .commit_data_rob  (commit_data_rob),
        .commit_idx_rob   (commit_idx_rob)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: program-order queue of live tags plus per-tag contents.
    bit        m_valid [16];
    bit        m_done  [16];
    bit [4:0]  m_rd    [16];
    bit [31:0] m_data  [16];
    bit [2:0]  m_slot  [16];
    int        order[$];
    int        m_tail = 0;

    always @(posedge clk or negedge rst) begin
        bit cm;
        bit al;
        int h;
        if (!rst) begin
            for (int i = 0; i < 16; i++) begin
                m_valid[i] = 0; m_done[i] = 0; m_rd[i] = 0; m_data[i] = 0; m_slot[i] = 0;
            end
            order.delete();
            m_tail = 0;
        end else begin
            cm = (order.size() > 0) && m_done[order[0]];
            al = load_rob_dec && (order.size() < 16);
            for (int i = 0; i < 16; i++) begin
                if (m_valid[i] && !m_done[i] && done_alurs[m_slot[i]]) begin
                    m_done[i] = 1;
                    m_data[i] = data_alurs[m_slot[i]];
                end
            end
            if (cm) begin
                h = order.pop_front();
                m_valid[h] = 0;
                m_done[h]  = 0;
            end
            if (al) begin
                m_valid[m_tail] = 1;
                m_done[m_tail]  = ready_dec;
                m_rd[m_tail]    = rd_dec;
                m_data[m_tail]  = ready_dec ? data_dec : 32'd0;
                m_slot[m_tail]  = widx_alurs;
                order.push_back(m_tail);
                m_tail = (m_tail + 1) % 16;
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0]       ed;
        logic [15:0][31:0] edata;
        bit                cv;
        for (int i = 0; i < 16; i++) begin
            ed[i]    = m_valid[i] && m_done[i];
            edata[i] = m_data[i];
        end
        cv = (order.size() > 0) && ed[order[0]];
        chk("m_widx", 512'(widx_rob), 512'(m_tail));
        chk("m_full", 512'(rob_full), 512'(order.size() == 16));
        chk("m_empty", 512'(rob_empty), 512'(order.size() == 0));
        chk("m_done_rob", 512'(done_rob), 512'(ed));
        chk("m_data_rob", 512'(data_rob), 512'(edata));
        chk("m_commit_valid", 512'(commit_valid_rob), 512'(cv));
        if (cv) begin
            chk("m_commit_rd", 512'(commit_rd_rob), 512'(m_rd[order[0]]));
            chk("m_commit_data", 512'(commit_data_rob), 512'(m_data[order[0]]));
            chk("m_commit_idx", 512'(commit_idx_rob), 512'(order[0]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [4:0] rd, input logic rdy, input logic [31:0] d, input logic [2:0] slot);
        load_rob_dec = 1'b1; rd_dec = rd; ready_dec = rdy; data_dec = d; widx_alurs = slot;
        tick();
        load_rob_dec = 1'b0; ready_dec = 1'b0; data_dec = '0;
    endtask

    task automatic complete(input int slot, input logic [31:0] d);
        done_alurs[slot] = 1'b1; data_alurs[slot] = d;
        tick();
        done_alurs = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        load_rob_dec = 0; rd_dec = 0; ready_dec = 0; data_dec = 0;
        widx_alurs = 0; done_alurs = 0; data_alurs = '0;
        repeat (2) tick();
        chk("rst_widx", 512'(widx_rob), 512'(0));
        chk("rst_empty", 512'(rob_empty), 512'(1));
        chk("rst_full", 512'(rob_full), 512'(0));
        chk("rst_done", 512'(done_rob), 512'(0));
        chk("rst_commit_valid", 512'(commit_valid_rob), 512'(0));
        rst = 1'b1;

        // Immediate result
        dispatch(5'd5, 1'b1, 32'h1234, 3'd0);
        chk("imm_done0", 512'(done_rob[0]), 512'(1));
        chk("imm_data0", 512'(data_rob[0]), 512'(32'h1234));
        chk("imm_cv", 512'(commit_valid_rob), 512'(1));
        chk("imm_crd", 512'(commit_rd_rob), 512'(5));
        chk("imm_cdata", 512'(commit_data_rob), 512'(32'h1234));
        chk("imm_cidx", 512'(commit_idx_rob), 512'(0));
        tick();
        chk("imm_empty", 512'(rob_empty), 512'(1));
        chk("imm_widx", 512'(widx_rob), 512'(1));

        // ALU capture through slot 3
        dispatch(5'd7, 1'b0, 32'h0, 3'd3);
        chk("alu_notdone", 512'(done_rob[1]), 512'(0));
        complete(3, 32'hDEADBEEF);
        chk("alu_done1", 512'(done_rob[1]), 512'(1));
        chk("alu_data1", 512'(data_rob[1]), 512'(32'hDEADBEEF));
        chk("alu_cidx", 512'(commit_idx_rob), 512'(1));
        tick();

        // Stale done on the slot during allocation must be ignored
        done_alurs[4] = 1'b1; data_alurs[4] = 32'h55;
        dispatch(5'd9, 1'b0, 32'h0, 3'd4);
        done_alurs = '0;
        chk("stale_nodone", 512'(done_rob[2]), 512'(0));
        tick();
        chk("stale_nodone2", 512'(done_rob[2]), 512'(0));
        complete(4, 32'h66);
        chk("stale_data", 512'(data_rob[2]), 512'(32'h66));
        tick();

        // Out-of-order completion, in-order commit
        dispatch(5'd1, 1'b0, 32'h0, 3'd0);
        dispatch(5'd2, 1'b0, 32'h0, 3'd1);
        dispatch(5'd3, 1'b0, 32'h0, 3'd2);
        done_alurs = 8'b0000_0110; data_alurs[1] = 32'h11; data_alurs[2] = 32'h22;
        tick();
        done_alurs = '0;
        chk("ooo_hold", 512'(commit_valid_rob), 512'(0));
        chk("ooo_done", 512'(done_rob[5:3]), 512'(3'b110));
        complete(0, 32'hA0);
        chk("ooo_c0_idx", 512'(commit_idx_rob), 512'(3));
        chk("ooo_c0_data", 512'(commit_data_rob), 512'(32'hA0));
        tick();
        chk("ooo_c1_idx", 512'(commit_idx_rob), 512'(4));
        chk("ooo_c1_rd", 512'(commit_rd_rob), 512'(2));
        tick();
        chk("ooo_c2_data", 512'(commit_data_rob), 512'(32'h22));
        tick();
        chk("ooo_empty", 512'(rob_empty), 512'(1));

        // Reset mid-stream with five live entries
        for (int i = 0; i < 5; i++) dispatch(5'(i + 1), 1'b0, 32'h0, 3'(i));
        complete(4, 32'h77);
        chk("mid_done10", 512'(done_rob[10]), 512'(1));
        rst = 1'b0;
        #1;
        chk("mid_done", 512'(done_rob), 512'(0));
        chk("mid_empty", 512'(rob_empty), 512'(1));
        chk("mid_widx", 512'(widx_rob), 512'(0));
        chk("mid_cv", 512'(commit_valid_rob), 512'(0));
        tick();
        rst = 1'b1;

        // Fill, refuse, commit head, wrap
        for (int i = 0; i < 16; i++) dispatch(5'(i + 1), 1'b0, 32'h0, 3'(i % 8));
        chk("full_flag", 512'(rob_full), 512'(1));
        chk("full_widx", 512'(widx_rob), 512'(0));
        load_rob_dec = 1'b1; rd_dec = 5'd31;
        tick();
        chk("full_refuse", 512'(widx_rob), 512'(0));
        done_alurs[0] = 1'b1; data_alurs[0] = 32'hC0;
        tick();
        done_alurs = '0;
        chk("full_cv", 512'(commit_valid_rob), 512'(1));
        chk("full_still", 512'(rob_full), 512'(1));
        chk("full_done8", 512'(done_rob[8]), 512'(1));
        tick();
        chk("full_freed", 512'(rob_full), 512'(0));
        chk("full_wrap_widx", 512'(widx_rob), 512'(0));
        tick();
        load_rob_dec = 1'b0;
        chk("full_again", 512'(rob_full), 512'(1));
        chk("full_widx1", 512'(widx_rob), 512'(1));

        // Concurrent allocate and commit at count 7
        do_reset();
        for (int i = 0; i < 7; i++) dispatch(5'(i + 1), 1'b0, 32'h0, 3'(i));
        complete(0, 32'hB0);
        chk("cc_cv", 512'(commit_valid_rob), 512'(1));
        dispatch(5'd20, 1'b0, 32'h0, 3'd7);
        chk("cc_widx", 512'(widx_rob), 512'(8));
        chk("cc_cv2", 512'(commit_valid_rob), 512'(0));
        chk("cc_done0", 512'(done_rob[0]), 512'(0));
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
